riscv_issue_scoreboard: RTL and testbench

Issue-side hazard controller for the 10-stage pipeline. It sits between ID and EX1 and decides every cycle whether the instruction in ID may advance into EX1 and read the register file. It tracks in-flight destination registers with per-register countdown counters and stalls ID on RAW hazards. It freezes tracking while downstream stages are held, and kills young entries on a branch-redirect flush.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/riscv_issue_scoreboard_if.sv | 34 +++
 rtl/riscv_sb_entry.sv | 41 ++++
 rtl/riscv_issue_scoreboard.sv | 92 +++++++++
 tb/tb_riscv_issue_scoreboard.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and types for the issue-side hazard logic.
//   RV_WB_LAT     - cycles from issue until the RF write is visible to an EX1 read
//   RV_FLUSH_KILL - how many of the youngest issue slots a redirect squashes
//   iss_state_e   - issue scoreboard FSM (RUN / FLUSH)
package riscv_pkg;

  localparam int RV_WB_LAT     = 7;
  localparam int RV_FLUSH_KILL = 2;

  typedef enum logic [0:0] {
    ISS_RUN   = 1'b0,
    ISS_FLUSH = 1'b1
  } iss_state_e;

endpackage

// File: rtl/riscv_issue_scoreboard_if.sv
// riscv_issue_scoreboard_if: ID <-> issue scoreboard signal bundle.
//   master : ID stage / pipeline control (drives instruction fields, hold, flush)
//   slave  : scoreboard (returns issue_ready/issue_fire, busy_vec, stall_cycles)
interface riscv_issue_scoreboard_if #(
  parameter int NUM_REGS = 32
) ();

  logic                id_valid;
  logic [4:0]          id_rs1_addr;
  logic                id_rs1_used;
  logic [4:0]          id_rs2_addr;
  logic                id_rs2_used;
  logic [4:0]          id_rd_addr;
  logic                id_rd_wen;
  logic                pipe_hold;
  logic                flush;
  logic                issue_ready;
  logic                issue_fire;
  logic [NUM_REGS-1:0] busy_vec;
  logic [31:0]         stall_cycles;

  modport master (
    output id_valid, id_rs1_addr, id_rs1_used, id_rs2_addr, id_rs2_used,
           id_rd_addr, id_rd_wen, pipe_hold, flush,
    input  issue_ready, issue_fire, busy_vec, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs1_used, id_rs2_addr, id_rs2_used,
           id_rd_addr, id_rd_wen, pipe_hold, flush,
    output issue_ready, issue_fire, busy_vec, stall_cycles
  );

endinterface

// File: rtl/riscv_sb_entry.sv
// riscv_sb_entry: one countdown counter of the issue scoreboard.
//   clk, rst_n : clock, async active-low reset
//   kill_i     : redirect; clears the counter if it is above KILL_THR
//   hold_i     : downstream freeze; counter holds
//   load_i     : producer issued to this register; counter := LOAD_VAL
//   dec_en_i   : allow the normal per-cycle decrement
//   cnt_o      : current count (0 = value readable from the RF)
module riscv_sb_entry #(
  parameter int               CNT_W    = 3,
  parameter logic [CNT_W-1:0] LOAD_VAL = '1,
  parameter logic [CNT_W-1:0] KILL_THR = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             kill_i,
  input  logic             hold_i,
  input  logic             load_i,
  input  logic             dec_en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Kill wins over hold so a redirect during a freeze still squashes young
  // producers; surviving entries then honour the hold.
  always_comb begin
    cnt_d = cnt_q;
    if (kill_i && (cnt_q > KILL_THR))  cnt_d = '0;
    else if (hold_i)                   cnt_d = cnt_q;
    else if (load_i)                   cnt_d = LOAD_VAL;
    else if (dec_en_i && cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/riscv_issue_scoreboard.sv
// riscv_issue_scoreboard: ID->EX1 issue gate with per-register countdown
// tracking of in-flight destinations. Stalls ID on RAW hazards, freezes on
// pipe_hold, squashes the youngest producers on a branch-redirect flush.
//   clk, rst_n : clock, async active-low reset
//   sb (slave) : id_* instruction fields, pipe_hold, flush in;
//                issue_ready/issue_fire (combinational), busy_vec,
//                stall_cycles (saturating) out
module riscv_issue_scoreboard
  import riscv_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int WB_LAT     = RV_WB_LAT,
  parameter int FWD_READY  = 0,
  parameter int FLUSH_KILL = RV_FLUSH_KILL,
  parameter int CNT_W      = $clog2(WB_LAT+1)
) (
  input logic                     clk,
  input logic                     rst_n,
  riscv_issue_scoreboard_if.slave sb
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WB_LAT);
  localparam logic [CNT_W-1:0] KILL_THR = CNT_W'(WB_LAT - FLUSH_KILL);
  localparam logic [CNT_W-1:0] FWD_THR  = CNT_W'(FWD_READY);

  iss_state_e                     state_q, state_d;
  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
  logic [NUM_REGS-1:0]            busy;
  logic                           rs1_ok, rs2_ok, ready, fire, ld_en, stall_inc;
  logic [31:0]                    stall_q, stall_d;

  // x0 is never tracked.
  assign cnt[0] = '0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_ent
    riscv_sb_entry #(
      .CNT_W    (CNT_W),
      .LOAD_VAL (LOAD_VAL),
      .KILL_THR (KILL_THR)
    ) u_ent (
      .clk      (clk),
      .rst_n    (rst_n),
      .kill_i   (sb.flush),
      .hold_i   (sb.pipe_hold),
      .load_i   (ld_en && (sb.id_rd_addr == 5'(i))),
      .dec_en_i (1'b1),
      .cnt_o    (cnt[i])
    );
  end

  always_comb begin
    busy = '0;
    for (int k = 0; k < NUM_REGS; k++) busy[k] = (cnt[k] != '0);
  end

  // Critical path: rs index -> cnt mux -> compare -> issue_ready.
  assign rs1_ok = !sb.id_rs1_used || (sb.id_rs1_addr == 5'd0) ||
                  (cnt[sb.id_rs1_addr] <= FWD_THR);
  assign rs2_ok = !sb.id_rs2_used || (sb.id_rs2_addr == 5'd0) ||
                  (cnt[sb.id_rs2_addr] <= FWD_THR);

  assign ready = (state_q == ISS_RUN) && !sb.flush && !sb.pipe_hold && rs1_ok && rs2_ok;
  assign fire  = sb.id_valid && ready;
  // fire is already 0 under flush, so a flushed instruction never loads.
  assign ld_en = fire && sb.id_rd_wen && (sb.id_rd_addr != 5'd0);

  // FLUSH lasts exactly one cycle, giving the redirect two dead issue slots.
  always_comb begin
    state_d = ISS_RUN;
    if (state_q == ISS_RUN && sb.flush) state_d = ISS_FLUSH;
  end

  assign stall_inc = sb.id_valid && (state_q == ISS_RUN) && !sb.flush &&
                     !sb.pipe_hold && !ready;
  assign stall_d   = (stall_inc && stall_q != 32'hFFFF_FFFF) ? stall_q + 32'd1 : stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ISS_RUN;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  assign sb.issue_ready  = ready;
  assign sb.issue_fire   = fire;
  assign sb.busy_vec     = busy;
  assign sb.stall_cycles = stall_q;

endmodule

// File: tb/tb_riscv_issue_scoreboard.sv
module tb_riscv_issue_scoreboard;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_issue_scoreboard_if #(.NUM_REGS(32)) sb_if ();

  riscv_issue_scoreboard dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb_if)
  );

  // One record = one (or rep identical) ID cycles, with the values expected
  // in that cycle (busy/stall are the registered values before the edge).
  typedef struct {
    logic        pr;       // pulse reset before applying
    logic        v;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic        wen;
    logic        hold;
    logic        flush;
    int          rep;
    logic        rdy;
    logic        fire;
    logic [31:0] busy;
  } vec_t;

  typedef struct {
    logic        rdy;
    logic        fire;
    logic [31:0] busy;
    logic [31:0] stall;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_stall = 0;
  logic prev_flush = 1'b0;

  function automatic vec_t mk(logic pr, logic v, logic [4:0] rs1, logic u1,
                              logic [4:0] rs2, logic u2, logic [4:0] rd, logic wen,
                              logic hold, logic flush, int rep, logic rdy,
                              logic fire, logic [31:0] busy);
    vec_t t;
    t.pr = pr; t.v = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2;
    t.rd = rd; t.wen = wen; t.hold = hold; t.flush = flush; t.rep = rep;
    t.rdy = rdy; t.fire = fire; t.busy = busy;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(vec_t t);
    sb_if.id_valid    = t.v;
    sb_if.id_rs1_addr = t.rs1;
    sb_if.id_rs1_used = t.u1;
    sb_if.id_rs2_addr = t.rs2;
    sb_if.id_rs2_used = t.u2;
    sb_if.id_rd_addr  = t.rd;
    sb_if.id_rd_wen   = t.wen;
    sb_if.pipe_hold   = t.hold;
    sb_if.flush       = t.flush;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(mk(0,0,0,0,0,0,0,0,0,0,1,1,0,0));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_stall  = 0;
    prev_flush = 1'b0;
  endtask

  task automatic apply(vec_t t);
    exp_t e, got;
    if (t.pr) do_reset();
    for (int r = 0; r < t.rep; r++) begin
      @(negedge clk);
      drive(t);
      e.rdy = t.rdy; e.fire = t.fire; e.busy = t.busy; e.stall = exp_stall;
      sbq.push_back(e);
      #1;
      got = sbq.pop_front();
      chk("issue_ready",  {31'd0, sb_if.issue_ready}, {31'd0, got.rdy});
      chk("issue_fire",   {31'd0, sb_if.issue_fire},  {31'd0, got.fire});
      chk("busy_vec",     sb_if.busy_vec,             got.busy);
      chk("stall_cycles", sb_if.stall_cycles,         got.stall);
      if (t.v && !t.rdy && !t.hold && !t.flush && !prev_flush) exp_stall++;
      prev_flush = t.flush;
    end
  endtask

  initial begin
    // independent ops: x5 producer, x6 consumer next cycle
    tbl.push_back(mk(0,1,0,0,0,0,5,1,0,0,1,1,1,32'h0));
    tbl.push_back(mk(0,1,6,1,0,0,0,0,0,0,1,1,1,32'h20));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,6,1,0,32'h20));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,1,0,32'h0));
    // RAW on x5: 7 stall cycles, consumer writes x8
    tbl.push_back(mk(0,1,0,0,0,0,5,1,0,0,1,1,1,32'h0));
    tbl.push_back(mk(0,1,5,1,0,0,8,1,0,0,7,0,0,32'h20));
    tbl.push_back(mk(0,1,5,1,0,0,8,1,0,0,1,1,1,32'h0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,7,1,0,32'h100));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,1,0,32'h0));
    // x0 never tracked; unused source ignored; used rs2 stalls
    tbl.push_back(mk(0,1,0,0,0,0,0,1,0,0,1,1,1,32'h0));
    tbl.push_back(mk(0,1,0,1,0,1,0,0,0,0,1,1,1,32'h0));
    tbl.push_back(mk(0,1,0,0,0,0,9,1,0,0,1,1,1,32'h0));
    tbl.push_back(mk(0,1,9,0,9,0,0,0,0,0,1,1,1,32'h200));
    tbl.push_back(mk(0,1,0,0,9,1,0,0,0,0,1,0,0,32'h200));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,5,1,0,32'h200));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,1,0,32'h0));
    // flush kill: x3,x4,x7 then flush (with a valid x10 that must not load)
    tbl.push_back(mk(0,1,0,0,0,0,3,1,0,0,1,1,1,32'h0));
    tbl.push_back(mk(0,1,0,0,0,0,4,1,0,0,1,1,1,32'h8));
    tbl.push_back(mk(0,1,0,0,0,0,7,1,0,0,1,1,1,32'h18));
    tbl.push_back(mk(0,1,0,0,0,0,10,1,0,1,1,0,0,32'h98));
    tbl.push_back(mk(0,1,0,0,0,0,10,1,0,0,1,0,0,32'h8));
    tbl.push_back(mk(0,1,3,1,0,0,0,0,0,0,3,0,0,32'h8));
    tbl.push_back(mk(0,1,3,1,0,0,0,0,0,0,1,1,1,32'h0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,1,0,32'h0));
    // pipe_hold freeze: x9 held 3 cycles, consumer (writes x11) 3 cycles late
    tbl.push_back(mk(0,1,0,0,0,0,9,1,0,0,1,1,1,32'h0));
    tbl.push_back(mk(0,1,9,1,0,0,11,1,1,0,3,0,0,32'h200));
    tbl.push_back(mk(0,1,9,1,0,0,11,1,0,0,7,0,0,32'h200));
    tbl.push_back(mk(0,1,9,1,0,0,11,1,0,0,1,1,1,32'h0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,7,1,0,32'h800));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,1,1,0,32'h0));
    // flush during hold: young x13 killed, older x12 holds
    tbl.push_back(mk(0,1,0,0,0,0,12,1,0,0,1,1,1,32'h0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,2,1,0,32'h1000));
    tbl.push_back(mk(0,1,0,0,0,0,13,1,0,0,1,1,1,32'h1000));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,1,1,0,0,32'h3000));
    tbl.push_back(mk(0,1,12,1,0,0,0,0,0,0,4,0,0,32'h1000));
    tbl.push_back(mk(0,1,12,1,0,0,0,0,0,0,1,1,1,32'h0));
    // build busy=0x220, stall=12 for the mid-operation reset
    tbl.push_back(mk(1,1,0,0,0,0,1,1,0,0,1,1,1,32'h0));
    tbl.push_back(mk(0,1,1,1,0,0,5,1,0,0,7,0,0,32'h2));
    tbl.push_back(mk(0,1,1,1,0,0,5,1,0,0,1,1,1,32'h0));
    tbl.push_back(mk(0,1,0,0,0,0,9,1,0,0,1,1,1,32'h20));
    tbl.push_back(mk(0,1,5,1,0,0,0,0,0,0,6,0,0,32'h220));

    // reset state
    drive(mk(0,0,0,0,0,0,0,0,0,0,1,1,0,0));
    #2;
    chk("rst busy_vec",   sb_if.busy_vec, 32'h0);
    chk("rst stall",      sb_if.stall_cycles, 32'h0);
    chk("rst issue_fire", {31'd0, sb_if.issue_fire}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // mid-operation reset: consumer of x5 still driven
    chk("pre-rst busy_vec", sb_if.busy_vec, 32'h220);
    chk("pre-rst stall",    sb_if.stall_cycles, 32'd12);
    #1 rst_n = 1'b0;
    #1;
    chk("async rst busy_vec", sb_if.busy_vec, 32'h0);
    chk("async rst stall",    sb_if.stall_cycles, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-rst issue_fire", {31'd0, sb_if.issue_fire}, 32'h1);
    chk("post-rst busy_vec",   sb_if.busy_vec, 32'h0);
    @(negedge clk);
    drive(mk(0,0,0,0,0,0,0,0,0,0,1,1,0,0));
    #1;
    chk("post-rst stall", sb_if.stall_cycles, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
